rtc_field_edit_ctrl: RTL and testbench
======================================

// Module: rtc_field_edit_ctrl
// PURPOSE
//  Lets one shared up/down BCD counter edit every clock/calendar field in turn.
//  Holds the 7 field values and loads the selected one into the counter with the right range code.
//  Translates user up/down pulses into single counter steps.
//  Captures the result and writes it back to the field register and the RTC/PicoBlaze write port.
//  Sits between the debounced button logic and the counter.
// PARAMETERS
//  NUM_FIELDS  7  fields in the edit sequence (index 0..NUM_FIELDS-1)
//  CMD_HOLD    2  clkm cycles each counter command (load/EN) stays asserted; the counter sees exactly one active edge
// PORTS
//  clkm       in   1  clock
//  reset      in   1  synchronous, active-high reset
//  edit_en    in   1  level: edit mode requested
//  btn_next   in   1  1-cycle pulse: commit current field, advance to next
//  btn_up     in   1  1-cycle pulse: increment current field
//  btn_down   in   1  1-cycle pulse: decrement current field
//  fmt_12h    in   1  1 = hour field uses the 12-h range, 0 = the 24-h range
//  cnt_bcd1   in   4  counter tens digit
//  cnt_bcd0   in   4  counter units digit
//  cnt_load   out  1  counter load strobe
//  cnt_dato   out  8  counter load data {tens,units}
//  cnt_en     out  1  counter enable
//  cnt_up     out  1  counter count-up
//  cnt_down   out  1  counter count-down
//  cnt_cod    out  3  counter range code
//  field_sel  out  3  field index being edited
//  wr_strobe  out  1  1-cycle write pulse to the RTC port
//  wr_addr    out  3  written field index
//  wr_data    out  8  written BCD value
//  busy       out  1  high in every state except IDLE and WAIT
// BEHAVIOUR
//  Reset values: all outputs 0; field_sel=0; all field registers 8'h00; FSM in IDLE.
//  Field map (index: cod):
//   0 seconds: 111
//   1 minutes: 011
//   2 hours: 001 if fmt_12h, else 010
//   3 day: 100
//   4 month: 101
//   5 year: 110
//   6 format: 000
//  The hour code is re-evaluated every cycle.
//  FSM states:
//   IDLE: wait for edit_en=1 -> LOAD (field_sel unchanged).
//   LOAD: cnt_load=1, cnt_dato=field[field_sel] for CMD_HOLD cycles -> WAIT.
//   WAIT: react to input events, highest priority first:
//    edit_en=0 -> WB_EXIT
//    btn_next -> WB_NEXT
//    btn_up -> STEP with dir=up
//    btn_down -> STEP with dir=down
//    (btn_up has priority over btn_down when both occur together)
//   STEP: cnt_en=1 plus cnt_up or cnt_down for CMD_HOLD cycles -> SETTLE.
//   SETTLE: CMD_HOLD idle cycles so the counter output is stable -> WAIT.
//   WB_NEXT / WB_EXIT: field[field_sel] <= {cnt_bcd1,cnt_bcd0}, with wr_strobe/addr/data for 1 cycle.
//    WB_NEXT: field_sel <= (field_sel==NUM_FIELDS-1) ? 0 : field_sel+1, then -> LOAD.
//    WB_EXIT: field_sel held, then -> IDLE.
//  Button pulses arriving in any state other than WAIT are dropped, not queued.
//  edit_en falling outside WAIT is honoured at the next WAIT (the step completes first).
//  cnt_cod is always driven from field_sel, including during LOAD.
//  Range wrap-around is done by the counter; this block does no BCD arithmetic.
//  Counter outputs are sampled only in WB states.
//  Reset mid-operation returns to IDLE on the next edge:
//   field registers are cleared and no write-back occurs;
//   counter command outputs drop the same cycle.
//  Latencies:
//   edit_en -> first cnt_load: 1 cycle.
//   btn_up -> cnt_en: 1 cycle.
//   btn_next -> wr_strobe: 1 cycle.
// STRUCTURE
//  Shared package rtc_pkg:
//   state encoding (localparams);
//   field index constants F_SEC..F_FMT;
//   COD_* range codes, shared with the counter.
//  One sub-module: rtc_field_cod_map, combinational (field_sel, fmt_12h) -> cnt_cod.
//  Everything else is local: FSM, hold counter (clog2(CMD_HOLD+1) bits), field register array.
// TESTING
//  1. Reset, then edit_en=1 -> cnt_load pulse with cnt_dato=8'h00 and cnt_cod=3'b111.
//  2. Counter model; 3 btn_up pulses, then btn_next -> wr_strobe, wr_addr=0, wr_data=8'h03; field_sel=1.
//  3. field 1 = 8'h59, btn_up, btn_next -> wr_data=8'h00 (counter wraps); field_sel=2 with cnt_cod=010.
//  4. fmt_12h=1 at field 2, btn_down from 8'h00 -> cnt_cod=001 and wr_data=8'h12.
//  5. btn_up and btn_down in the same cycle -> exactly one up step. A btn_up during SETTLE is ignored (value +1 only).
//  6. At field 6, btn_next -> field_sel=0. Reset asserted during STEP -> IDLE next cycle, no wr_strobe, fields=0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC field editor: FSM states, field indices and
// counter range codes (the range codes are also decoded by the BCD counter).
package rtc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_STEP,
      ST_SETTLE,
      ST_WB_NEXT,
      ST_WB_EXIT
   } state_t;

   localparam logic [2:0] F_SEC  = 3'd0;
   localparam logic [2:0] F_MIN  = 3'd1;
   localparam logic [2:0] F_HOUR = 3'd2;
   localparam logic [2:0] F_DAY  = 3'd3;
   localparam logic [2:0] F_MON  = 3'd4;
   localparam logic [2:0] F_YEAR = 3'd5;
   localparam logic [2:0] F_FMT  = 3'd6;

   localparam logic [2:0] COD_FMT  = 3'b000;
   localparam logic [2:0] COD_H12  = 3'b001;
   localparam logic [2:0] COD_H24  = 3'b010;
   localparam logic [2:0] COD_MIN  = 3'b011;
   localparam logic [2:0] COD_DAY  = 3'b100;
   localparam logic [2:0] COD_MON  = 3'b101;
   localparam logic [2:0] COD_YEAR = 3'b110;
   localparam logic [2:0] COD_SEC  = 3'b111;

endpackage

// File: rtl/rtc_field_cod_map.sv
// Maps the field being edited to the counter range code; the hour range
// follows fmt_12h combinationally.
module rtc_field_cod_map
   import rtc_pkg::*;
(
   input  logic [2:0] field_sel,
   input  logic       fmt_12h,
   output logic [2:0] cnt_cod
);

   always_comb begin
      cnt_cod = COD_FMT;
      case (field_sel)
         F_SEC:   cnt_cod = COD_SEC;
         F_MIN:   cnt_cod = COD_MIN;
         F_HOUR:  cnt_cod = fmt_12h ? COD_H12 : COD_H24;
         F_DAY:   cnt_cod = COD_DAY;
         F_MON:   cnt_cod = COD_MON;
         F_YEAR:  cnt_cod = COD_YEAR;
         F_FMT:   cnt_cod = COD_FMT;
         default: cnt_cod = COD_FMT;
      endcase
   end

endmodule

// File: rtl/rtc_field_edit_ctrl.sv
// Drives one shared BCD up/down counter to edit each clock/calendar field in
// turn, writing the edited value back to the field store and the RTC port.
module rtc_field_edit_ctrl
   import rtc_pkg::*;
#(
   parameter int NUM_FIELDS = 7,
   parameter int CMD_HOLD   = 2
)(
   input  logic       clkm,
   input  logic       reset,
   input  logic       edit_en,
   input  logic       btn_next,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       fmt_12h,
   input  logic [3:0] cnt_bcd1,
   input  logic [3:0] cnt_bcd0,
   output logic       cnt_load,
   output logic [7:0] cnt_dato,
   output logic       cnt_en,
   output logic       cnt_up,
   output logic       cnt_down,
   output logic [2:0] cnt_cod,
   output logic [2:0] field_sel,
   output logic       wr_strobe,
   output logic [2:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);

   localparam int HW = $clog2(CMD_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(CMD_HOLD - 1);
   localparam logic [2:0]    SEL_LAST  = 3'(NUM_FIELDS - 1);

   state_t          state, state_n;
   logic [HW-1:0]   hold;
   logic            dir_up, dir_n;
   logic [7:0]      field_q [NUM_FIELDS];
   logic [7:0]      cnt_val;
   logic            hold_last;

   assign cnt_val   = {cnt_bcd1, cnt_bcd0};
   assign hold_last = (hold == HOLD_LAST);

   rtc_field_cod_map u_cod_map (
      .field_sel (field_sel),
      .fmt_12h   (fmt_12h),
      .cnt_cod   (cnt_cod)
   );

   always_ff @(posedge clkm) begin
      if (reset) begin
         state     <= ST_IDLE;
         hold      <= '0;
         dir_up    <= 1'b0;
         field_sel <= '0;
         for (int unsigned i = 0; i < NUM_FIELDS; i++) field_q[i] <= '0;
      end else begin
         state  <= state_n;
         dir_up <= dir_n;
         // hold counts cycles spent in the current state; restarts on every transition
         hold   <= (state_n != state) ? '0 : hold + 1'b1;
         if (state == ST_WB_NEXT || state == ST_WB_EXIT)
            field_q[field_sel] <= cnt_val;
         if (state == ST_WB_NEXT)
            field_sel <= (field_sel == SEL_LAST) ? '0 : field_sel + 3'd1;
      end
   end

   always_comb begin
      state_n   = state;
      dir_n     = dir_up;
      cnt_load  = 1'b0;
      cnt_dato  = '0;
      cnt_en    = 1'b0;
      cnt_up    = 1'b0;
      cnt_down  = 1'b0;
      wr_strobe = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (edit_en) state_n = ST_LOAD;
         end
         ST_LOAD: begin
            cnt_load = 1'b1;
            cnt_dato = field_q[field_sel];
            if (hold_last) state_n = ST_WAIT;
         end
         ST_WAIT: begin
            busy = 1'b0;
            if (!edit_en)      state_n = ST_WB_EXIT;
            else if (btn_next) state_n = ST_WB_NEXT;
            else if (btn_up) begin
               state_n = ST_STEP;
               dir_n   = 1'b1;
            end else if (btn_down) begin
               state_n = ST_STEP;
               dir_n   = 1'b0;
            end
         end
         ST_STEP: begin
            cnt_en   = 1'b1;
            cnt_up   = dir_up;
            cnt_down = !dir_up;
            if (hold_last) state_n = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (hold_last) state_n = ST_WAIT;
         end
         ST_WB_NEXT, ST_WB_EXIT: begin
            wr_strobe = 1'b1;
            wr_addr   = field_sel;
            wr_data   = cnt_val;
            state_n   = (state == ST_WB_NEXT) ? ST_LOAD : ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
      // reset silences the counter and RTC port in the same cycle, not one edge later
      if (reset) begin
         cnt_load  = 1'b0;
         cnt_dato  = '0;
         cnt_en    = 1'b0;
         cnt_up    = 1'b0;
         cnt_down  = 1'b0;
         wr_strobe = 1'b0;
         wr_addr   = '0;
         wr_data   = '0;
         busy      = 1'b0;
      end
   end

endmodule

// File: tb/tb_rtc_field_edit_ctrl.sv
// Bench for rtc_field_edit_ctrl: behavioural wrap-around BCD counter plus a
// write-port scoreboard of expected {addr,data} records.
module tb_rtc_field_edit_ctrl;

   logic       clkm = 1'b0;
   logic       reset, edit_en, btn_next, btn_up, btn_down, fmt_12h;
   logic [3:0] cnt_bcd1, cnt_bcd0;
   logic       cnt_load, cnt_en, cnt_up, cnt_down, wr_strobe, busy;
   logic [7:0] cnt_dato, wr_data;
   logic [2:0] cnt_cod, field_sel, wr_addr;

   int n_cmp = 0;
   int n_bad = 0;
   logic [10:0] exp_q [$];

   rtc_field_edit_ctrl #(.NUM_FIELDS(7), .CMD_HOLD(2)) dut (
      .clkm(clkm), .reset(reset), .edit_en(edit_en), .btn_next(btn_next),
      .btn_up(btn_up), .btn_down(btn_down), .fmt_12h(fmt_12h),
      .cnt_bcd1(cnt_bcd1), .cnt_bcd0(cnt_bcd0), .cnt_load(cnt_load),
      .cnt_dato(cnt_dato), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_down(cnt_down),
      .cnt_cod(cnt_cod), .field_sel(field_sel), .wr_strobe(wr_strobe),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   always #5 clkm = ~clkm;

   // Counter model: acts once per command, on the rising edge of load/en.
   logic [7:0] cval = 8'h00;
   logic       prev_load = 1'b0, prev_en = 1'b0;
   assign cnt_bcd1 = cval[7:4];
   assign cnt_bcd0 = cval[3:0];

   function automatic logic [7:0] cnt_step(input logic [7:0] v, input logic [2:0] cod, input logic up);
      int b, lo, hi;
      b = int'(v[7:4]) * 10 + int'(v[3:0]);
      case (cod)
         3'b111, 3'b011: begin lo = 0; hi = 59; end
         3'b010:         begin lo = 0; hi = 23; end
         3'b001, 3'b101: begin lo = 1; hi = 12; end
         3'b100:         begin lo = 1; hi = 31; end
         3'b110:         begin lo = 0; hi = 99; end
         default:        begin lo = 0; hi = 1;  end
      endcase
      if (up) b = (b >= hi) ? lo : b + 1;
      else    b = (b <= lo) ? hi : b - 1;
      return {4'(b / 10), 4'(b % 10)};
   endfunction

   always @(posedge clkm) begin
      if (cnt_load && !prev_load) cval = cnt_dato;
      if (cnt_en && !prev_en) cval = cnt_step(cval, cnt_cod, cnt_up);
      prev_load = cnt_load;
      prev_en   = cnt_en;
   end

   always @(negedge clkm) begin
      if (wr_strobe) begin
         logic [10:0] e;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               n_bad++;
               $display("FAIL wr_port: got addr=%0d data=%h, required addr=%0d data=%h",
                        wr_addr, wr_data, e[10:8], e[7:0]);
            end
         end
      end
   end

   task automatic pulse_btn(input logic u, input logic d, input logic n);
      @(negedge clkm);
      btn_up = u; btn_down = d; btn_next = n;
      @(negedge clkm);
      btn_up = 1'b0; btn_down = 1'b0; btn_next = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge clkm);
         if (!busy) break;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_timeout: busy=%b after 40 cycles, required 0", name, busy);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; edit_en = 1'b0; btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0; fmt_12h = 1'b0;
      repeat (3) @(negedge clkm);
      n_cmp++;
      if ({cnt_load, cnt_en, cnt_up, cnt_down, wr_strobe, busy, cnt_dato, field_sel} !== 17'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: got load/en/up/dn/wr/busy=%b%b%b%b%b%b dato=%h sel=%0d, required all 0",
                  cnt_load, cnt_en, cnt_up, cnt_down, wr_strobe, busy, cnt_dato, field_sel);
      end
      reset = 1'b0;
      @(negedge clkm);
      edit_en = 1'b1;
      @(negedge clkm);
      n_cmp++;
      if ({cnt_load, cnt_dato, cnt_cod} !== {1'b1, 8'h00, 3'b111}) begin
         n_bad++;
         $display("FAIL first_load: got load=%b dato=%h cod=%b, required load=1 dato=00 cod=111",
                  cnt_load, cnt_dato, cnt_cod);
      end
      wait_ready("first_load");
   endtask

   task automatic test_step_up;
      repeat (3) begin
         pulse_btn(1'b1, 1'b0, 1'b0);
         wait_ready("step_up");
      end
      exp_q.push_back({3'd0, 8'h03});
      pulse_btn(1'b0, 1'b0, 1'b1);
      wait_ready("next0");
      n_cmp++;
      if (field_sel !== 3'd1) begin
         n_bad++;
         $display("FAIL next_sel1: got field_sel=%0d, required 1", field_sel);
      end
   endtask

   task automatic test_wrap_minutes;
      pulse_btn(1'b0, 1'b1, 1'b0);
      wait_ready("min_down");
      pulse_btn(1'b1, 1'b0, 1'b0);
      wait_ready("min_up");
      exp_q.push_back({3'd1, 8'h00});
      pulse_btn(1'b0, 1'b0, 1'b1);
      wait_ready("next1");
      n_cmp++;
      if ({field_sel, cnt_cod} !== {3'd2, 3'b010}) begin
         n_bad++;
         $display("FAIL hour24_cod: got sel=%0d cod=%b, required sel=2 cod=010", field_sel, cnt_cod);
      end
   endtask

   task automatic test_hour12;
      @(negedge clkm);
      fmt_12h = 1'b1;
      #1;
      n_cmp++;
      if (cnt_cod !== 3'b001) begin
         n_bad++;
         $display("FAIL hour12_cod: got cod=%b, required 001", cnt_cod);
      end
      pulse_btn(1'b0, 1'b1, 1'b0);
      wait_ready("hour_down");
      exp_q.push_back({3'd2, 8'h12});
      pulse_btn(1'b0, 1'b0, 1'b1);
      wait_ready("next2");
   endtask

   task automatic test_priority_and_settle;
      pulse_btn(1'b1, 1'b1, 1'b0);
      n_cmp++;
      if ({cnt_en, cnt_up, cnt_down} !== 3'b110) begin
         n_bad++;
         $display("FAIL updown_prio: got en/up/down=%b%b%b, required 110", cnt_en, cnt_up, cnt_down);
      end
      @(negedge clkm);
      @(negedge clkm);
      btn_up = 1'b1;
      @(negedge clkm);
      btn_up = 1'b0;
      n_cmp++;
      if (cnt_en !== 1'b0) begin
         n_bad++;
         $display("FAIL settle_drop: got cnt_en=%b after btn_up in SETTLE, required 0", cnt_en);
      end
      wait_ready("settle");
      exp_q.push_back({3'd3, 8'h01});
      pulse_btn(1'b0, 1'b0, 1'b1);
      wait_ready("next3");
   endtask

   task automatic test_field_wrap_and_reset;
      exp_q.push_back({3'd4, 8'h00});
      pulse_btn(1'b0, 1'b0, 1'b1);
      wait_ready("next4");
      exp_q.push_back({3'd5, 8'h00});
      pulse_btn(1'b0, 1'b0, 1'b1);
      wait_ready("next5");
      exp_q.push_back({3'd6, 8'h00});
      pulse_btn(1'b0, 1'b0, 1'b1);
      @(negedge clkm);
      n_cmp++;
      if ({field_sel, cnt_load, cnt_dato} !== {3'd0, 1'b1, 8'h03}) begin
         n_bad++;
         $display("FAIL sel_wrap: got sel=%0d load=%b dato=%h, required sel=0 load=1 dato=03",
                  field_sel, cnt_load, cnt_dato);
      end
      wait_ready("wrap_load");
      pulse_btn(1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({cnt_en, cnt_up, cnt_down} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_cmd_drop: got en/up/down=%b%b%b, required 000", cnt_en, cnt_up, cnt_down);
      end
      @(negedge clkm);
      n_cmp++;
      if ({busy, field_sel} !== 4'h0) begin
         n_bad++;
         $display("FAIL reset_idle: got busy=%b sel=%0d, required busy=0 sel=0", busy, field_sel);
      end
      reset = 1'b0;
      @(negedge clkm);
      n_cmp++;
      if ({cnt_load, cnt_dato} !== {1'b1, 8'h00}) begin
         n_bad++;
         $display("FAIL reset_cleared: got load=%b dato=%h, required load=1 dato=00", cnt_load, cnt_dato);
      end
      wait_ready("post_reset");
   endtask

   task automatic test_exit;
      pulse_btn(1'b1, 1'b0, 1'b0);
      edit_en = 1'b0;
      exp_q.push_back({3'd0, 8'h01});
      wait_ready("exit_step");
      @(negedge clkm);
      @(negedge clkm);
      n_cmp++;
      if ({busy, cnt_load, field_sel} !== 5'h0) begin
         n_bad++;
         $display("FAIL exit_idle: got busy=%b load=%b sel=%0d, required 0 0 0", busy, cnt_load, field_sel);
      end
      edit_en = 1'b1;
      @(negedge clkm);
      n_cmp++;
      if ({cnt_load, cnt_dato} !== {1'b1, 8'h01}) begin
         n_bad++;
         $display("FAIL exit_stored: got load=%b dato=%h, required load=1 dato=01", cnt_load, cnt_dato);
      end
      wait_ready("reenter");
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL wr_missing: %0d expected writes never seen, required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset;
      test_step_up;
      test_wrap_minutes;
      test_hour12;
      test_priority_and_settle;
      test_field_wrap_and_reset;
      test_exit;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded 200000 time units, required completion");
      $fatal(1);
   end

endmodule
